imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate extender.
- Accepts the 25-bit instruction immediate field (instr[31:7]) plus a format selector through a valid/ready handshake.
- Produces the sign- or zero-extended XLEN-bit immediate through a 2-entry output buffer.
- Sits between decode and the execute operand mux; lets decode stall independently of execute.

---
 rtl/imm_gen_pipe_pkg.sv | 40 ++++
 rtl/imm_gen_pipe_if.sv | 30 +++
 rtl/imm_gen_pipe_ext_core.sv | 38 +++
 rtl/imm_gen_pipe.sv | 92 +++++++++
 tb/tb_imm_gen_pipe.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: shared types and helpers for the pipelined immediate generator.
//   imm_fmt_e   - immediate format selector (matches the immsrc encoding)
//   IMM_FIELD_W - width of the instruction immediate field, instr[31:7]
//   imm_extend  - 64-bit reference extension; callers truncate to their XLEN
package imm_pkg;

  localparam int IMM_FIELD_W = 25;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_BAD = 3'b111
  } imm_fmt_e;

  // imm[k] corresponds to instr[k+7]. The result is sign-correct for both
  // XLEN=32 and XLEN=64 when truncated to the low xlen bits.
  function automatic logic [63:0] imm_extend(input logic [IMM_FIELD_W-1:0] imm,
                                             input imm_fmt_e fmt,
                                             input int xlen);
    logic [63:0] r;
    r = '0;
    case (fmt)
      IMM_I:  r = 64'($signed(imm[24:13]));
      IMM_S:  r = 64'($signed({imm[24:18], imm[4:0]}));
      IMM_B:  r = 64'($signed({imm[24], imm[0], imm[23:18], imm[4:1], 1'b0}));
      IMM_U:  r = 64'($signed({imm[24:5], 12'b0}));
      IMM_J:  r = 64'($signed({imm[24], imm[12:5], imm[13], imm[23:14], 1'b0}));
      IMM_Z:  r = 64'(imm[12:8]);
      IMM_SH: r = (xlen == 64) ? 64'(imm[18:13]) : 64'(imm[17:13]);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: request/response bundle of the immediate generator.
//   in_valid/in_ready  - request handshake (producer = decode)
//   imm, immsrc        - instr[31:7] and format select
//   out_valid/out_ready- response handshake (consumer = execute operand mux)
//   immext, illegal    - extended immediate and unsupported-format flag
// Modports: master = decode/execute side, slave = imm_gen_pipe.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [IMM_FIELD_W-1:0] imm;
  imm_fmt_e               immsrc;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        immext;
  logic                   illegal;

  modport master (
    output in_valid, imm, immsrc, out_ready,
    input  in_ready, out_valid, immext, illegal
  );

  modport slave (
    input  in_valid, imm, immsrc, out_ready,
    output in_ready, out_valid, immext, illegal
  );
endinterface

// File: rtl/imm_gen_pipe_ext_core.sv
// imm_ext_core: purely combinational immediate extractor.
//   imm     in  25    instr[31:7]
//   fmt     in  3     format select
//   immext  out XLEN  sign/zero-extended immediate
//   illegal out 1     fmt is the unsupported encoding
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [IMM_FIELD_W-1:0] imm,
  input  imm_fmt_e               fmt,
  output logic [XLEN-1:0]        immext,
  output logic                   illegal
);

  // A size cast of a signed operand sign-extends, which avoids zero-width
  // replications when XLEN=32.
  always_comb begin
    immext  = '0;
    illegal = 1'b0;
    case (fmt)
      IMM_I:  immext = XLEN'($signed(imm[24:13]));
      IMM_S:  immext = XLEN'($signed({imm[24:18], imm[4:0]}));
      IMM_B:  immext = XLEN'($signed({imm[24], imm[0], imm[23:18], imm[4:1], 1'b0}));
      IMM_U:  immext = XLEN'($signed({imm[24:5], 12'b0}));
      IMM_J:  immext = XLEN'($signed({imm[24], imm[12:5], imm[13], imm[23:14], 1'b0}));
      IMM_Z:  immext = XLEN'(imm[12:8]);
      IMM_SH: begin
        if (XLEN == 64) immext = XLEN'(imm[18:13]);
        else            immext = XLEN'(imm[17:13]);
      end
      IMM_BAD: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate extender with a DEPTH-entry output buffer.
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   bus          slave modport of imm_gen_pipe_if (request/response handshake)
//   illegal_cnt  out  16-bit saturating count of pushes with immsrc=111;
//                     present only when IMM_STATS_EN is defined
// Parameters: XLEN (32|64) output width, DEPTH (1|2) buffer entries.
// The extension is computed at push and stored, so out_valid rises exactly
// one cycle after a push; in_ready depends only on the registered count.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_gen_pipe_if.slave bus
`ifdef IMM_STATS_EN
  ,
  output logic [15:0]   illegal_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] buf_val [DEPTH];
  logic            buf_ill [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [1:0]      count;
  logic [XLEN-1:0] ext_val;
  logic            ext_ill;
  logic            push;
  logic            pop;

  imm_ext_core #(.XLEN(XLEN)) u_core (
    .imm     (bus.imm),
    .fmt     (bus.immsrc),
    .immext  (ext_val),
    .illegal (ext_ill)
  );

  assign bus.in_ready  = (count < 2'(DEPTH));
  assign bus.out_valid = (count != 2'd0);
  assign bus.immext    = buf_val[rd_ptr];
  assign bus.illegal   = buf_ill[rd_ptr];

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_val[i] <= '0;
        buf_ill[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_val[wr_ptr] <= ext_val;
        buf_ill[wr_ptr] <= ext_ill;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

`ifdef IMM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (push && ext_ill && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();

`ifdef IMM_STATS_EN
  logic [15:0] cnt32;
  logic [15:0] cnt64;
`endif

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32)
`ifdef IMM_STATS_EN
    ,
    .illegal_cnt (cnt32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b64)
`ifdef IMM_STATS_EN
    ,
    .illegal_cnt (cnt64)
`endif
  );

  int unsigned tot = 0;
  int unsigned bad = 0;
  logic [64:0] q[$];        // expected buffer contents: {illegal, value}
  int unsigned ill_model = 0;
  int unsigned ill64 = 0;
  bit pushed = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: rebuild instr and assemble each immediate arithmetically from
  // the standard instruction fields.
  function automatic logic [63:0] ref_ext(input logic [24:0] f, input int fmt, input int xlen);
    logic [31:0] ins;
    longint v;
    longint sgn;
    ins = {f, 7'b0};
    sgn = ins[31] ? 1 : 0;
    case (fmt)
      0: v = longint'(ins[31:20]) - sgn * 4096;
      1: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - sgn * 4096;
      2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
             + longint'(ins[11:8]) * 2 - sgn * 4096;
      3: v = longint'(ins[31:12]) * 4096 - sgn * (longint'(1) << 32);
      4: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
             + longint'(ins[30:21]) * 2 - sgn * (longint'(1) << 20);
      5: v = longint'(ins[19:15]);
      6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return 64'(v);
  endfunction

  // Called at a falling edge with inputs for the next rising edge in place.
  task automatic cyc32();
    bit exp_ov;
    bit exp_ir;
    exp_ov = (q.size() != 0);
    exp_ir = (q.size() < 2);
    chk("out_valid", 64'(b32.out_valid), 64'(exp_ov));
    chk("in_ready", 64'(b32.in_ready), 64'(exp_ir));
    if (exp_ov) begin
      chk("immext", 64'(b32.immext), q[0][63:0]);
      chk("illegal", 64'(b32.illegal), 64'(q[0][64]));
    end
`ifdef IMM_STATS_EN
    chk("illegal_cnt", 64'(cnt32), 64'(ill_model));
`endif
    if (exp_ov && b32.out_ready) q.delete(0);
    pushed = b32.in_valid && exp_ir;
    if (pushed) begin
      q.push_back({b32.immsrc == IMM_BAD, ref_ext(b32.imm, int'(b32.immsrc), 32)});
      if (b32.immsrc == IMM_BAD && ill_model < 65535) ill_model++;
    end
    @(negedge clk);
  endtask

  task automatic drive32(input bit v, input logic [24:0] i, input int f);
    b32.in_valid = v;
    b32.imm      = i;
    b32.immsrc   = imm_fmt_e'(f);
  endtask

  task automatic one32(input string tag, input logic [24:0] i, input int f, input logic [63:0] exp);
    b32.out_ready = 1'b1;
    drive32(1'b1, i, f);
    cyc32();
    b32.in_valid = 1'b0;
    chk({tag, "_ov"}, 64'(b32.out_valid), 64'd1);
    chk(tag, 64'(b32.immext), exp);
    chk({tag, "_ill"}, 64'(b32.illegal), 64'(f == 7));
    cyc32();
  endtask

  task automatic one64(input string tag, input logic [24:0] i, input int f, input logic [63:0] exp);
    b64.in_valid  = 1'b1;
    b64.imm       = i;
    b64.immsrc    = imm_fmt_e'(f);
    b64.out_ready = 1'b1;
    chk({tag, "_ir"}, 64'(b64.in_ready), 64'd1);
    if (f == 7) ill64++;
    @(negedge clk);
    b64.in_valid = 1'b0;
    chk({tag, "_ov"}, 64'(b64.out_valid), 64'd1);
    chk(tag, b64.immext, exp);
    chk({tag, "_ill"}, 64'(b64.illegal), 64'(f == 7));
    @(negedge clk);
    chk({tag, "_empty"}, 64'(b64.out_valid), 64'd0);
  endtask

  task automatic drain32(input int budget);
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    for (int k = 0; k < budget && q.size() != 0; k++) cyc32();
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    drive32(1'b0, '0, 0);
    b32.out_ready = 1'b0;
    b64.in_valid  = 1'b0;
    b64.imm       = '0;
    b64.immsrc    = IMM_I;
    b64.out_ready = 1'b0;

    // reset values
    #1;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_immext", 64'(b32.immext), 64'd0);
    chk("rst_illegal", 64'(b32.illegal), 64'd0);
    chk("rst_out_valid64", 64'(b64.out_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(b32.in_ready), 64'd1);
    @(negedge clk);

    // directed single-format sweep, XLEN=32
    one32("addi_m1", 25'h1FFE001, 0, 64'hFFFF_FFFF);
    one32("lui", 25'h02468A1, 3, 64'h1234_5000);
    one32("beq_m4", 25'h1FC001D, 2, 64'hFFFF_FFFC);
    one32("shamt32", 25'h007E000, 6, 64'd31);
    one32("zimm", 25'h0001F00, 5, 64'd31);
    one32("bad", 25'h1FFFFFF, 7, 64'd0);

    // back-pressure: third request must stall, head stays put
    b32.out_ready = 1'b0;
    drive32(1'b1, 25'h0000123, 0); cyc32();
    drive32(1'b1, 25'h1ABCDEF, 1); cyc32();
    drive32(1'b1, 25'h0F0F0F0, 4);
    for (int k = 0; k < 3; k++) cyc32();
    b32.out_ready = 1'b1;
    for (int k = 0; k < 10 && b32.in_valid; k++) begin
      cyc32();
      if (pushed) b32.in_valid = 1'b0;
    end
    chk("bp_third_accepted", 64'(b32.in_valid), 64'd0);
    drain32(10);

    // streaming push+pop with one entry resident
    b32.out_ready = 1'b1;
    drive32(1'b1, 25'($urandom), $urandom_range(0, 6)); cyc32();
    for (int k = 0; k < 10; k++) begin
      drive32(1'b1, 25'($urandom), $urandom_range(0, 7));
      cyc32();
    end
    drain32(10);

    // three illegal pushes back to back
    for (int k = 0; k < 3; k++) begin
      drive32(1'b1, 25'($urandom), 7);
      cyc32();
    end
    drain32(10);

    // randomized traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      if (!(b32.in_valid && !pushed)) begin
        drive32($urandom_range(0, 3) != 0, 25'($urandom), $urandom_range(0, 7));
      end
      b32.out_ready = ($urandom_range(0, 2) != 0);
      cyc32();
    end
    drain32(20);

    // XLEN=64 instance
    one64("u64_neg", 25'h1000000, 3, 64'hFFFF_FFFF_8000_0000);
    one64("shamt64", 25'h007E000, 6, 64'd63);
    one64("bad64", 25'h0123456, 7, 64'd0);
    for (int k = 0; k < 40; k++) begin
      logic [24:0] ri;
      int rf;
      ri = 25'($urandom);
      rf = $urandom_range(0, 7);
      one64("rand64", ri, rf, ref_ext(ri, rf, 64));
    end
`ifdef IMM_STATS_EN
    chk("illegal_cnt64", 64'(cnt64), 64'(ill64));
`endif

    // asynchronous reset with two entries buffered
    b32.out_ready = 1'b0;
    drive32(1'b1, 25'h1FFE001, 0); cyc32();
    drive32(1'b1, 25'h02468A1, 7); cyc32();
    b32.in_valid = 1'b0;
    chk("pre_rst_full", 64'(b32.in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("arst_immext", 64'(b32.immext), 64'd0);
    chk("arst_illegal", 64'(b32.illegal), 64'd0);
`ifdef IMM_STATS_EN
    chk("arst_illegal_cnt", 64'(cnt32), 64'd0);
`endif
    q.delete();
    ill_model = 0;
    pushed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cyc32();
    one32("post_rst_push", 25'h02468A1, 3, 64'h1234_5000);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
